// File: rtl/fetch_snoopqueue.sv
// fetch_snoopqueue
//   In-order shift FIFO of pending fetch line addresses. Fetch pushes a line
//   address when a refill/invalidate is launched and pops it on retirement.
//   NQ parallel query ports report line-granular hits on any in-flight entry,
//   so the fetch/prefetch paths can stall or replay.
//
//   Entry 0 is the oldest. Valid entries are contiguous from 0. Queries are
//   combinational on registered state. A same-cycle push is not visible, and a
//   same-cycle popped entry still is.
//
// Optional build macro:
//   SNOOPQUEUE_BYPASS_EN - an accepted, non-flushed push also hits queries in
//                          its own cycle (and counts as head when empty).
//
// Ports:
//   clk, resetn          clock (rising edge), async active-low reset
//   flush                synchronous clear of entries and overflow
//   push_valid/addr      enqueue request; push_ready = ~full | pop
//   pop                  retire oldest entry (ignored when empty)
//   q_addr               NQ query addresses, port k at [k*ADDR_W +: ADDR_W]
//   q_hit, q_hit_oldest  per-port hit / hit on head entry
//   count, empty, full   occupancy status (registered)
//   overflow             sticky: push dropped while full
module fetch_snoopqueue #(
  parameter int DEPTH       = 6,
  parameter int ADDR_W      = 32,
  parameter int LINE_OFFSET = 6,
  parameter int NQ          = 2,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 push_valid,
  input  logic [ADDR_W-1:0]    push_addr,
  output logic                 push_ready,
  input  logic                 pop,
  input  logic [NQ*ADDR_W-1:0] q_addr,
  output logic [NQ-1:0]        q_hit,
  output logic [NQ-1:0]        q_hit_oldest,
  output logic [CNT_W-1:0]     count,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow
);

  localparam int LINE_W = ADDR_W - LINE_OFFSET;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              r_pop;
  logic              push_acc;
  logic [CNT_W-1:0]  wr_idx;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign count      = count_q;
  assign overflow   = overflow_q;

  assign r_pop      = pop & ~empty;
  assign push_ready = ~full | pop;
  assign push_acc   = push_valid & push_ready;
  // With a simultaneous pop everything shifts down, so the tail slot is count-1.
  assign wr_idx     = r_pop ? (count_q - CNT_W'(1)) : count_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    addr_d     = addr_q;
    valid_d    = valid_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (flush) begin
      // Flush wins over push and pop; the pushed address is discarded.
      valid_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (r_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) addr_d[i] = addr_q[i+1];
        valid_d = valid_q >> 1;
      end
      if (push_acc) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == wr_idx) begin
            addr_d[i]  = push_addr;
            valid_d[i] = 1'b1;
          end
        end
      end
      case ({push_acc, r_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (push_valid && !push_ready) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      valid_q    <= valid_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: address storage is deliberately not reset; the valid bits qualify every entry.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  always_comb begin
    q_hit        = '0;
    q_hit_oldest = '0;
    for (int k = 0; k < NQ; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] &&
            addr_q[i][ADDR_W-1:LINE_OFFSET] == q_addr[k*ADDR_W+LINE_OFFSET +: LINE_W])
          q_hit[k] = 1'b1;
      end
      q_hit_oldest[k] = valid_q[0] &&
          (addr_q[0][ADDR_W-1:LINE_OFFSET] == q_addr[k*ADDR_W+LINE_OFFSET +: LINE_W]);
`ifdef SNOOPQUEUE_BYPASS_EN
      if (push_acc && !flush &&
          push_addr[ADDR_W-1:LINE_OFFSET] == q_addr[k*ADDR_W+LINE_OFFSET +: LINE_W]) begin
        q_hit[k] = 1'b1;
        // An accepted push into an empty queue becomes the head.
        if (empty) q_hit_oldest[k] = 1'b1;
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_fetch_snoopqueue.sv
// Bench for fetch_snoopqueue (default parameters). A queue-based model tracks
// the pending line addresses; every falling edge compares all DUT outputs to
// it, and directed scenarios add literal expectations that pin the model.
module tb_fetch_snoopqueue;

  localparam int DEPTH = 6;
  localparam int ADDR_W = 32;
  localparam int LOFF = 6;
  localparam int NQ = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic              push_valid;
  logic [ADDR_W-1:0] push_addr;
  logic              push_ready;
  logic              pop;
  logic [ADDR_W-1:0] q0, q1;
  logic [NQ*ADDR_W-1:0] q_addr;
  logic [NQ-1:0]     q_hit, q_hit_oldest;
  logic [CNT_W-1:0]  count;
  logic              empty, full, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  assign q_addr = {q1, q0};

  always #5 clk = ~clk;

  fetch_snoopqueue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_OFFSET(LOFF), .NQ(NQ)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .push_valid(push_valid), .push_addr(push_addr), .push_ready(push_ready),
    .pop(pop), .q_addr(q_addr), .q_hit(q_hit), .q_hit_oldest(q_hit_oldest),
    .count(count), .empty(empty), .full(full), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: list of pending addresses, oldest first ----------
  logic [ADDR_W-1:0] mq[$];
  bit                m_ovf;

  function automatic bit same_line(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return (a >> LOFF) == (b >> LOFF);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      bit rdy;
      rdy = (mq.size() < DEPTH) || pop;
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (push_valid && rdy) mq.push_back(push_addr);
      else if (push_valid) m_ovf = 1'b1;
    end
  end

  function automatic bit exp_hit(input logic [ADDR_W-1:0] qa);
    bit h = 1'b0;
    foreach (mq[i]) if (same_line(mq[i], qa)) h = 1'b1;
`ifdef SNOOPQUEUE_BYPASS_EN
    if (push_valid && ((mq.size() < DEPTH) || pop) && !flush && same_line(push_addr, qa)) h = 1'b1;
`endif
    return h;
  endfunction

  function automatic bit exp_oldest(input logic [ADDR_W-1:0] qa);
    bit h = (mq.size() > 0) && same_line(mq[0], qa);
`ifdef SNOOPQUEUE_BYPASS_EN
    if (mq.size() == 0 && push_valid && !flush && same_line(push_addr, qa)) h = 1'b1;
`endif
    return h;
  endfunction

  // Compare process: outputs vs model every falling edge.
  always @(negedge clk) begin
    check("count", 32'(count), 32'(mq.size()));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("push_ready", 32'(push_ready), 32'((mq.size() < DEPTH) || pop));
    check("q_hit", 32'(q_hit), 32'({exp_hit(q1), exp_hit(q0)}));
    check("q_hit_oldest", 32'(q_hit_oldest), 32'({exp_oldest(q1), exp_oldest(q0)}));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a);
    push_valid = 1'b1;
    push_addr  = a;
    step();
    push_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; push_valid = 1'b0; push_addr = '0; pop = 1'b0;
    q0 = '0; q1 = '0;
    repeat (2) step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    resetn = 1'b1;
    step();

    // Three pushes, head query, miss on unrelated line.
    push(32'h1000_0040); push(32'h1000_0080); push(32'h2000_0000);
    q0 = 32'h1000_007F; q1 = 32'h1000_00C0;
    #1;
    check("t1_count", 32'(count), 32'd3);
    check("t1_hit", 32'(q_hit), 32'b01);
    check("t1_oldest", 32'(q_hit_oldest), 32'b01);

    // Fill, overflow, then push+pop while full.
    push(32'h3000_0000); push(32'h3000_0040); push(32'h3000_0080);
    push_valid = 1'b1; push_addr = 32'h4000_0000;
    #1;
    check("t2_ready_full", 32'(push_ready), 32'd0);
    step();
    check("t2_count", 32'(count), 32'd6);
    check("t2_overflow", 32'(overflow), 32'd1);
    push_addr = 32'h5000_0000; pop = 1'b1;
    step();
    push_valid = 1'b0; pop = 1'b0;
    q0 = 32'h5000_0000; q1 = 32'h1000_0040;
    #1;
    check("t2_pp_count", 32'(count), 32'd6);
    check("t2_pp_hit", 32'(q_hit), 32'b01);

    // Seven pops drain six entries; extra pop is harmless.
    pop = 1'b1;
    repeat (7) step();
    pop = 1'b0;
    q0 = 32'h5000_0000; q1 = 32'h2000_0000;
    #1;
    check("t3_count", 32'(count), 32'd0);
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_hit", 32'(q_hit), 32'b00);

    // Flush beats push and pop, clears overflow.
    push(32'h1100_0000); push(32'h1100_0040); push(32'h1100_0080);
    check("t4_ovf_before", 32'(overflow), 32'd1);
    flush = 1'b1; push_valid = 1'b1; push_addr = 32'h6000_0000; pop = 1'b1;
    step();
    flush = 1'b0; push_valid = 1'b0; pop = 1'b0;
    q0 = 32'h6000_0000; q1 = 32'h1100_0000;
    #1;
    check("t4_count", 32'(count), 32'd0);
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_overflow", 32'(overflow), 32'd0);
    check("t4_hit", 32'(q_hit), 32'b00);

    // Same-cycle push visibility.
    push_valid = 1'b1; push_addr = 32'h7000_0000; q0 = 32'h7000_0000;
    #1;
`ifdef SNOOPQUEUE_BYPASS_EN
    check("t5_same_cycle", 32'(q_hit[0]), 32'd1);
`else
    check("t5_same_cycle", 32'(q_hit[0]), 32'd0);
`endif
    step();
    push_valid = 1'b0;
    #1;
    check("t5_next_cycle", 32'(q_hit[0]), 32'd1);

    // Asynchronous reset mid-cycle with 4 entries and a pending push.
    push(32'h7100_0000); push(32'h7200_0000); push(32'h7300_0000);
    push_valid = 1'b1; push_addr = 32'h8000_0000; q0 = 32'h7000_0000;
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_hit", 32'(q_hit[0]), 32'd0);
    step();
    resetn = 1'b1; q0 = 32'h8000_0000;
    step();
    push_valid = 1'b0;
    #1;
    check("t6_count", 32'(count), 32'd1);
    check("t6_oldest", 32'(q_hit_oldest[0]), 32'd1);
    check("t6_hit", 32'(q_hit[0]), 32'd1);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
